// File: rtl/pipe_pkg.sv
// pipe_pkg: shared pipeline constants (Tnew width default, NOP encoding, reset PC default).
package pipe_pkg;
  localparam int TNEW_W_DEF = 4;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
endpackage

// File: rtl/tnew_sat_dec.sv
// tnew_sat_dec: combinational saturating decrement of a Tnew value (0 stays 0).
module tnew_sat_dec #(
  parameter int TNEW_W = 4
) (
  input  logic [TNEW_W-1:0] tnew,
  output logic [TNEW_W-1:0] dec
);
  assign dec = (tnew == '0) ? '0 : tnew - TNEW_W'(1);
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: pipeline stage register with stall/flush and Tnew aging.
// Define PIPE_STAGE_BUBBLE_CNT_EN to build the saturating bubble counter.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int          DATA_W   = 64,
  parameter int          TNEW_W   = TNEW_W_DEF,
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              flush,
  input  logic [31:0]       in_pc,
  input  logic [31:0]       in_instr,
  input  logic [DATA_W-1:0] in_payload,
  input  logic [4:0]        in_a3,
  input  logic              in_grf_write,
  input  logic [TNEW_W-1:0] in_tnew,
  input  logic              in_valid,
  output logic [31:0]       out_pc,
  output logic [31:0]       out_instr,
  output logic [DATA_W-1:0] out_payload,
  output logic [4:0]        out_a3,
  output logic              out_grf_write,
  output logic [TNEW_W-1:0] out_tnew,
  output logic              out_valid,
  output logic [31:0]       bubble_cnt
);
  logic [TNEW_W-1:0] tnew_dec;
  tnew_sat_dec #(.TNEW_W(TNEW_W)) u_dec (.tnew(in_tnew), .dec(tnew_dec));
  // A bubble keeps the stalled instruction's PC so exception logic still sees a valid EPC.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_pc        <= RESET_PC;
      out_instr     <= NOP_INSTR;
      out_payload   <= '0;
      out_a3        <= '0;
      out_grf_write <= 1'b0;
      out_tnew      <= '0;
      out_valid     <= 1'b0;
    end else if (flush) begin
      out_pc        <= in_pc;
      out_instr     <= NOP_INSTR;
      out_payload   <= '0;
      out_a3        <= '0;
      out_grf_write <= 1'b0;
      out_tnew      <= '0;
      out_valid     <= 1'b0;
    end else if (en) begin
      out_pc        <= in_pc;
      out_instr     <= in_instr;
      out_payload   <= in_payload;
      out_a3        <= in_a3;
      out_grf_write <= in_grf_write;
      out_tnew      <= tnew_dec;
      out_valid     <= in_valid;
    end
  end
`ifdef PIPE_STAGE_BUBBLE_CNT_EN
  logic [31:0] bubble_cnt_q;
  always_ff @(posedge clk) begin
    if (reset) bubble_cnt_q <= '0;
    else if (flush && bubble_cnt_q != '1) bubble_cnt_q <= bubble_cnt_q + 32'd1;
  end
  assign bubble_cnt = bubble_cnt_q;
`else
  assign bubble_cnt = '0;
`endif
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed and random checks of pipe_stage_reg against a behavioural model.
module tb_pipe_stage_reg;
  import pipe_pkg::*;
`ifdef PIPE_STAGE_BUBBLE_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif
  localparam logic [31:0] RPC = 32'h0000_3000;
  logic clk = 1'b0, reset, en, flush, in_grf_write, in_valid, out_grf_write, out_valid;
  logic [31:0] in_pc, in_instr, out_pc, out_instr, bubble_cnt;
  logic [63:0] in_payload, out_payload;
  logic [4:0] in_a3, out_a3;
  logic [3:0] in_tnew, out_tnew;
  int n_vec = 0, n_err = 0;
  logic [31:0] m_pc, m_instr;
  logic [63:0] m_payload;
  logic [4:0] m_a3;
  logic m_gw, m_valid;
  int m_tnew;
  longint m_cnt;
  always #5 clk = ~clk;
  pipe_stage_reg #(.DATA_W(64), .TNEW_W(4), .RESET_PC(RPC)) dut (
    .clk(clk), .reset(reset), .en(en), .flush(flush),
    .in_pc(in_pc), .in_instr(in_instr), .in_payload(in_payload), .in_a3(in_a3),
    .in_grf_write(in_grf_write), .in_tnew(in_tnew), .in_valid(in_valid),
    .out_pc(out_pc), .out_instr(out_instr), .out_payload(out_payload), .out_a3(out_a3),
    .out_grf_write(out_grf_write), .out_tnew(out_tnew), .out_valid(out_valid),
    .bubble_cnt(bubble_cnt));
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask
  // Model: a stage is an instruction slot; a bubble is an empty slot tagged with the PC.
  task automatic model_edge();
    if (reset) begin
      m_pc = RPC; m_instr = 0; m_payload = 0; m_a3 = 0; m_gw = 0; m_tnew = 0; m_valid = 0; m_cnt = 0;
    end else if (flush) begin
      m_pc = in_pc; m_instr = 0; m_payload = 0; m_a3 = 0; m_gw = 0; m_tnew = 0; m_valid = 0;
      if (CNT_ON) m_cnt = (m_cnt + 1 > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_cnt + 1;
    end else if (en) begin
      m_pc = in_pc; m_instr = in_instr; m_payload = in_payload; m_a3 = in_a3;
      m_gw = in_grf_write; m_valid = in_valid;
      m_tnew = (int'(in_tnew) > 0) ? int'(in_tnew) - 1 : 0;
    end
  endtask
  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    chk({tag, "_pc"}, out_pc, m_pc);
    chk({tag, "_instr"}, out_instr, m_instr);
    chk({tag, "_payload"}, out_payload, m_payload);
    chk({tag, "_a3"}, out_a3, m_a3);
    chk({tag, "_gw"}, out_grf_write, m_gw);
    chk({tag, "_tnew"}, out_tnew, m_tnew[3:0]);
    chk({tag, "_valid"}, out_valid, m_valid);
    chk({tag, "_cnt"}, bubble_cnt, m_cnt[31:0]);
  endtask
  task automatic drive(input logic r, input logic e, input logic f, input logic [31:0] pc,
                       input logic [3:0] tn, input logic [4:0] a3, input logic gw);
    reset = r; en = e; flush = f; in_pc = pc; in_tnew = tn; in_a3 = a3; in_grf_write = gw;
    in_instr = $urandom; in_payload = {$urandom, $urandom}; in_valid = 1'b1;
  endtask
  initial begin
    logic [31:0] held_pc;
    logic [3:0] held_tnew;
    longint prev_cnt;
    m_cnt = 0;
    drive(1, 0, 0, 32'h0, 4'h0, 5'd0, 0);
    tick("reset");
    chk("r026_pc", out_pc, RPC);
    chk("r026_valid", out_valid, 0);
    chk("r026_tnew", out_tnew, 0);
    chk("r026_cnt", bubble_cnt, 0);
    drive(0, 1, 0, 32'h3004, 4'd2, 5'd5, 1);
    tick("load");
    chk("r027_pc", out_pc, 32'h3004);
    chk("r027_tnew", out_tnew, 4'd1);
    chk("r027_a3", out_a3, 5'd5);
    chk("r027_gw", out_grf_write, 1);
    drive(0, 1, 0, 32'h3010, 4'h0, 5'd7, 1);
    tick("tnew0");
    chk("r028_tnew0", out_tnew, 4'h0);
    drive(0, 1, 0, 32'h3014, 4'hF, 5'd8, 1);
    tick("tnewf");
    chk("r028_tnewf", out_tnew, 4'hE);
    prev_cnt = m_cnt;
    drive(0, 0, 1, 32'h3008, 4'h3, 5'd9, 1);
    tick("flush");
    chk("r029_pc", out_pc, 32'h3008);
    chk("r029_instr", out_instr, NOP_INSTR);
    chk("r029_gw", out_grf_write, 0);
    chk("r029_valid", out_valid, 0);
    chk("r029_cnt", bubble_cnt, CNT_ON ? prev_cnt[31:0] + 32'd1 : 32'd0);
    drive(0, 1, 0, 32'h3020, 4'd3, 5'd11, 1);
    tick("preload");
    held_pc = out_pc;
    held_tnew = out_tnew;
    chk("r030_loaded_tnew", out_tnew, 4'd2);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 32'hDEAD_0000 + i, 4'd9, 5'd31, 0);
      tick("hold");
      chk("r030_pc", out_pc, held_pc);
      chk("r030_tnew", out_tnew, held_tnew);
    end
    drive(0, 1, 0, 32'h3030, 4'd4, 5'd12, 1);
    tick("load2");
    drive(1, 1, 1, 32'h3040, 4'd4, 5'd13, 1);
    tick("rst_flush");
    chk("r031_pc", out_pc, RPC);
    chk("r031_gw", out_grf_write, 0);
    chk("r031_cnt", bubble_cnt, 0);
`ifdef PIPE_STAGE_BUBBLE_CNT_EN
    force dut.bubble_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.bubble_cnt_q;
    m_cnt = 64'hFFFF_FFFE;
    drive(0, 0, 1, 32'h3050, 4'd1, 5'd1, 1);
    tick("sat1");
    tick("sat2");
    chk("r031_sat", bubble_cnt, 32'hFFFF_FFFF);
`endif
    for (int i = 0; i < 300; i++) begin
      drive($urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
            $urandom, 4'($urandom), 5'($urandom), 1'($urandom));
      in_valid = 1'($urandom);
      tick("rand");
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 The module SHALL take parameter DATA_W (default 64): width of the opaque control/data payload bundle.
REQ-002 The module SHALL take parameter TNEW_W (default 4): width of the Tnew/Tuse fields.
REQ-003 The module SHALL take parameter RESET_PC (default 32'h0000_0000): PC value loaded on reset.
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on posedge.
REQ-005 The module SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The module SHALL have ports en (input, 1, load enable; 0 = stall/hold) and flush (input, 1, insert bubble).
REQ-007 The module SHALL have inputs in_pc (32), in_instr (32), in_payload (DATA_W), in_a3 (5), in_grf_write (1), in_tnew (TNEW_W) and in_valid (1).
REQ-008 The module SHALL have outputs out_pc (32), out_instr (32), out_payload (DATA_W), out_a3 (5), out_grf_write (1), out_tnew (TNEW_W) and out_valid (1), all registered.
REQ-009 The module SHALL have output bubble_cnt, 32 bits: count of inserted bubbles.

Function
REQ-010 Update priority per posedge SHALL be reset > flush > en > hold.
REQ-011 On a load (en=1, flush=0), each out_* SHALL take its in_* one cycle later, except out_tnew.
REQ-012 On a load, out_tnew SHALL be the saturating decrement of in_tnew: 0 stays 0, otherwise in_tnew-1; no wrap to all-ones.
REQ-013 On a hold (en=0, flush=0), all outputs SHALL keep their values, including out_tnew (no decrement while held).
REQ-014 On a flush, the outputs SHALL be: out_instr=0, out_payload=0, out_a3=0, out_grf_write=0, out_tnew=0, out_valid=0.
REQ-015 On a flush, out_pc SHALL be loaded with in_pc, so the bubble carries the PC of the stalled instruction for exception/EPC use.
REQ-016 Flush SHALL take effect regardless of en; flush with en=0 is the normal stall-bubble case.
REQ-017 A bubble SHALL never assert out_grf_write, so it creates no forwarding or hazard source downstream.
REQ-018 Load latency SHALL be exactly 1 cycle, with no combinational path from any input to any output.

Reset
REQ-019 On reset=1 at posedge, out_pc SHALL be RESET_PC and every other output, including bubble_cnt, SHALL be 0.
REQ-020 Reset asserted mid-stall or together with flush SHALL win fully; the first posedge after deassert follows REQ-010.

Configuration
REQ-021 With macro PIPE_STAGE_BUBBLE_CNT_EN defined, bubble_cnt SHALL increment by 1 on each posedge where reset=0 and flush=1.
REQ-022 With PIPE_STAGE_BUBBLE_CNT_EN defined, bubble_cnt SHALL saturate at 32'hFFFF_FFFF.
REQ-023 Without PIPE_STAGE_BUBBLE_CNT_EN, bubble_cnt SHALL be a constant 0 and no counter logic SHALL be synthesised.

Structure
REQ-024 A shared package pipe_pkg SHALL hold TNEW_W default, the NOP instruction constant (32'h0) and the default RESET_PC.
REQ-025 The saturating decrement SHALL be a sub-module tnew_sat_dec (parameter TNEW_W, combinational), instantiated once.

Verification
REQ-026 The bench SHALL check: reset=1 one cycle -> out_pc=RESET_PC, out_valid=0, out_tnew=0, bubble_cnt=0.
REQ-027 The bench SHALL check: en=1, in_pc=32'h3004, in_tnew=2, in_a3=5, in_grf_write=1 -> next cycle out_pc=32'h3004, out_tnew=1, out_a3=5, out_grf_write=1.
REQ-028 The bench SHALL check: en=1, in_tnew=0 -> out_tnew=0; with TNEW_W=4, in_tnew=4'hF -> out_tnew=4'hE.
REQ-029 The bench SHALL check: en=0, flush=1, in_pc=32'h3008 -> out_pc=32'h3008, out_instr=0, out_grf_write=0, out_valid=0; bubble_cnt+1 (macro on) or 0 (macro off).
REQ-030 The bench SHALL check: load then en=0, flush=0 for 3 cycles -> outputs unchanged, out_tnew not decremented.
REQ-031 The bench SHALL check: reset=1 and flush=1 together after a load -> reset values; with bubble_cnt preset to 32'hFFFF_FFFE, two flushes -> 32'hFFFF_FFFF held.
